mem_wb_skid: RTL

Parametrised elastic MEM/WB pipeline stage. It carries the memory-stage result bundle (control bits, ALU result, load data, destination register) to writeback over a valid/ready handshake. A 2-entry skid buffer gives full throughput with no combinational ready path. The stage adds flush, a writeback-data select, a gated register-file write enable and a retire counter. It replaces the single-register MEM/WB latch that only had a stall input.

---
 rtl/mem_wb_skid.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_wb_skid.sv
// Elastic MEM/WB pipeline stage: a 2-entry skid buffer carries the memory-stage
// result bundle to writeback, with flush, writeback-data select and a retire counter.
module mem_wb_skid #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // upstream side
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  input  logic [DATA_W-1:0] ALUresult_i,
  input  logic [DATA_W-1:0] Readdata_i,
  input  logic [RD_W-1:0]   INS_11_7_i,
  input  logic              flush_i,
  // downstream side
  output logic              valid_o,
  input  logic              ready_i,
  output logic              RegWrite_o,
  output logic              MemToReg_o,
  output logic [DATA_W-1:0] ALUresult_o,
  output logic [DATA_W-1:0] Readdata_o,
  output logic [RD_W-1:0]   INS_11_7_o,
  output logic [DATA_W-1:0] WBdata_o,
  output logic              RegWriteEn_o,
  output logic [CNT_W-1:0]  retired_o,
  // debug view of the buffer state (0 empty, 1 one entry, 2 full)
  output logic [1:0]        dbg_state_o
);

  // Handshake: a bundle moves across an interface on every rising edge where
  // valid and ready are both high; a producer holding valid keeps its payload
  // stable until that edge, and ready never depends combinationally on the
  // downstream ready_i (it comes from registered state and rst_i only).

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
    logic [RD_W-1:0]   rd;
  } bundle_t;

  state_t           state;
  bundle_t          main_q;
  bundle_t          skid_q;
  bundle_t          in_b;
  logic             main_valid;
  logic             skid_valid;
  logic             accept;
  logic             transfer;
  logic [CNT_W-1:0] retired_q;

  assign in_b = '{
    reg_write:  RegWrite_i,
    mem_to_reg: MemToReg_i,
    alu_result: ALUresult_i,
    read_data:  Readdata_i,
    rd:         INS_11_7_i
  };

  assign main_valid = (state != S_EMPTY);
  assign skid_valid = (state == S_FULL);

  assign ready_o  = !skid_valid && !rst_i;
  assign accept   = valid_i && ready_o;
  assign transfer = main_valid && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      retired_q <= '0;
    end else begin
      // A transfer in a flush cycle was already sampled downstream, so it retires.
      if (transfer) begin
        retired_q <= retired_q + 1'b1;
      end
      if (flush_i) begin
        state <= S_EMPTY;
      end else begin
        unique case (state)
          S_EMPTY: begin
            if (accept) begin
              main_q <= in_b;
              state  <= S_ONE;
            end
          end
          S_ONE: begin
            if (accept && transfer) begin
              main_q <= in_b;
            end else if (accept) begin
              skid_q <= in_b;
              state  <= S_FULL;
            end else if (transfer) begin
              state <= S_EMPTY;
            end
          end
          S_FULL: begin
            if (transfer) begin
              main_q <= skid_q;
              state  <= S_ONE;
            end
          end
          default: state <= S_EMPTY;
        endcase
      end
    end
  end

  assign valid_o     = main_valid;
  assign RegWrite_o  = main_q.reg_write;
  assign MemToReg_o  = main_q.mem_to_reg;
  assign ALUresult_o = main_q.alu_result;
  assign Readdata_o  = main_q.read_data;
  assign INS_11_7_o  = main_q.rd;
  assign retired_o   = retired_q;
  assign dbg_state_o = state;

  assign WBdata_o     = main_q.mem_to_reg ? main_q.read_data : main_q.alu_result;
  // x0 is hardwired zero, so writes to it are suppressed here.
  assign RegWriteEn_o = main_valid && main_q.reg_write && (main_q.rd != '0);

endmodule
